// File: rtl/mem_wb_if.sv
// rtl/mem_wb_if.sv - MEM to WB stage instruction handoff bus
interface mem_wb_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_to_reg;
    logic                  reg_write_in;
    logic [2:0]            funct3;
    logic [2:0]            byte_off;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       mem_rdata;
    logic [REG_ADDR_W-1:0] rd_in;

    modport master (
        output in_valid,
        output mem_to_reg,
        output reg_write_in,
        output funct3,
        output byte_off,
        output alu_result,
        output mem_rdata,
        output rd_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  mem_to_reg,
        input  reg_write_in,
        input  funct3,
        input  byte_off,
        input  alu_result,
        input  mem_rdata,
        input  rd_in,
        output in_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline register, load extraction and register file write port
module mem_wb_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    mem_wb_if.slave               mem,
    output logic [XLEN-1:0]       WriteData,
    output logic [REG_ADDR_W-1:0] RD,
    output logic                  RegWrite,
    output logic                  wb_valid,
    output logic                  load_fault,
    output logic [CNT_W-1:0]      retired_count
);

    logic                  valid;
    logic                  consumed;
    logic                  e_mem_to_reg;
    logic                  e_reg_write;
    logic [2:0]            e_funct3;
    logic [2:0]            e_byte_off;
    logic [XLEN-1:0]       e_alu_result;
    logic [XLEN-1:0]       e_mem_rdata;
    logic [REG_ADDR_W-1:0] e_rd;

    logic [XLEN-1:0]       shifted;
    logic [XLEN-1:0]       load_data;
    logic                  misaligned;
    logic                  illegal;
    logic                  fault;
    logic                  present;

    assign mem.in_ready = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid        <= 1'b0;
            consumed     <= 1'b0;
            e_mem_to_reg <= 1'b0;
            e_reg_write  <= 1'b0;
            e_funct3     <= '0;
            e_byte_off   <= '0;
            e_alu_result <= '0;
            e_mem_rdata  <= '0;
            e_rd         <= '0;
        end else if (flush) begin
            valid    <= 1'b0;
            consumed <= 1'b0;
        end else if (stall) begin
            // a held entry has already been shown once; keep it from writing again
            consumed <= valid;
        end else begin
            valid        <= mem.in_valid;
            consumed     <= 1'b0;
            e_mem_to_reg <= mem.mem_to_reg;
            e_reg_write  <= mem.reg_write_in;
            e_funct3     <= mem.funct3;
            e_byte_off   <= mem.byte_off;
            e_alu_result <= mem.alu_result;
            e_mem_rdata  <= mem.mem_rdata;
            e_rd         <= mem.rd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (wb_valid) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    assign shifted = e_mem_rdata >> {e_byte_off, 3'b000};

    always_comb begin
        load_data  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (e_funct3)
            3'b000: load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001: begin
                load_data  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                misaligned = e_byte_off[0];
            end
            3'b010: begin
                load_data  = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                misaligned = |e_byte_off[1:0];
            end
            3'b011: begin
                load_data  = shifted;
                misaligned = |e_byte_off;
            end
            3'b100: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101: begin
                load_data  = {{(XLEN-16){1'b0}}, shifted[15:0]};
                misaligned = e_byte_off[0];
            end
            3'b110: begin
                load_data  = {{(XLEN-32){1'b0}}, shifted[31:0]};
                misaligned = |e_byte_off[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault   = e_mem_to_reg & (misaligned | illegal);
    assign present = valid & ~consumed;

    assign WriteData  = valid ? (e_mem_to_reg ? load_data : e_alu_result) : '0;
    assign RD         = valid ? e_rd : '0;
    assign wb_valid   = present;
    assign load_fault = present & fault;
    assign RegWrite   = present & e_reg_write & (e_rd != '0) & ~fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed and randomized checks of mem_wb_stage against a reference model
module tb_mem_wb_stage;
    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic reset, stall, flush;
    always #5 clk = ~clk;

    mem_wb_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus();

    logic [XLEN-1:0] write_data;
    logic [RW-1:0]   rd;
    logic            reg_write, wb_valid, load_fault;
    logic [CW-1:0]   retired_count;

    mem_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem(bus),
        .WriteData(write_data), .RD(rd), .RegWrite(reg_write), .wb_valid(wb_valid),
        .load_fault(load_fault), .retired_count(retired_count)
    );

    int passed = 0;
    int total  = 0;

    logic        m_valid = 1'b0, m_new = 1'b0, m_mtr = 1'b0, m_rw = 1'b0;
    logic [2:0]  m_f3 = '0, m_off = '0;
    logic [63:0] m_alu = '0, m_data = '0;
    logic [4:0]  m_rd = '0;
    int          m_count = 0;

    function automatic int load_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] data);
        logic [63:0] w;
        int n;
        if (f3 == 3'b111) return 64'd0;
        n = load_bytes(f3) * 8;
        w = data >> (8 * int'(off));
        if (n == 64) return w;
        w = w % (64'd1 << n);
        if (!f3[2] && w >= (64'd1 << (n - 1))) w = w - (64'd1 << n);
        return w;
    endfunction

    function automatic logic ref_fault(input logic mtr, input logic [2:0] f3, input logic [2:0] off);
        return mtr && (f3 == 3'b111 || (int'(off) % load_bytes(f3)) != 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic mtr, input logic rw, input logic [2:0] f3,
                         input logic [2:0] off, input logic [63:0] alu, input logic [63:0] data,
                         input logic [4:0] r);
        bus.in_valid     = v;
        bus.mem_to_reg   = mtr;
        bus.reg_write_in = rw;
        bus.funct3       = f3;
        bus.byte_off     = off;
        bus.alu_result   = alu;
        bus.mem_rdata    = data;
        bus.rd_in        = r;
    endtask

    task automatic check_outputs(input string tag);
        logic present, flt;
        present = m_valid && m_new;
        flt     = m_valid && ref_fault(m_mtr, m_f3, m_off);
        chk({tag, "_wd"}, write_data, !m_valid ? 64'd0 : (m_mtr ? ref_load(m_f3, m_off, m_data) : m_alu));
        chk({tag, "_rd"}, rd, m_valid ? m_rd : 5'd0);
        chk({tag, "_wbv"}, wb_valid, present);
        chk({tag, "_flt"}, load_fault, present && flt);
        chk({tag, "_rw"}, reg_write, present && m_rw && m_rd != 0 && !flt);
        chk({tag, "_cnt"}, retired_count, 64'(m_count));
        chk({tag, "_rdy"}, bus.in_ready, !stall);
    endtask

    // model state advances on the same stimulus the DUT sees at the coming edge
    task automatic step(input string tag);
        if (!reset && m_valid && m_new) m_count = (m_count + 1) % (1 << CW);
        if (reset) begin
            m_valid = 1'b0; m_new = 1'b0; m_count = 0;
        end else if (flush) begin
            m_valid = 1'b0; m_new = 1'b0;
        end else if (stall) begin
            m_new = 1'b0;
        end else begin
            m_valid = bus.in_valid; m_new = bus.in_valid;
            m_mtr = bus.mem_to_reg; m_rw = bus.reg_write_in; m_f3 = bus.funct3;
            m_off = bus.byte_off; m_alu = bus.alu_result; m_data = bus.mem_rdata; m_rd = bus.rd_in;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0, 5'd0);
        step("reset1");
        step("reset2");
        chk("rst_wd", write_data, 64'd0);
        chk("rst_cnt", retired_count, 64'd0);
        reset = 1'b0;

        drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'h1234, 64'd0, 5'd12);
        step("alu");
        chk("alu_wd_lit", write_data, 64'h1234);
        chk("alu_rd_lit", rd, 64'd12);
        chk("alu_rw_lit", reg_write, 64'd1);

        drive(1'b1, 1'b1, 1'b1, 3'b000, 3'd3, 64'd0, 64'h0000_0000_8000_0000, 5'd5);
        step("lb");
        chk("lb_wd_lit", write_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("alu_cnt_lit", retired_count, 64'd1);

        drive(1'b1, 1'b1, 1'b1, 3'b110, 3'd4, 64'd0, 64'hDEAD_BEEF_0000_0000, 5'd7);
        step("lwu");
        chk("lwu_wd_lit", write_data, 64'h0000_0000_DEAD_BEEF);

        drive(1'b1, 1'b1, 1'b1, 3'b010, 3'd2, 64'd0, 64'h1111_2222_3333_4444, 5'd9);
        step("lw_mis");
        chk("lw_mis_flt_lit", load_fault, 64'd1);
        chk("lw_mis_rw_lit", reg_write, 64'd0);

        drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'h55, 64'd0, 5'd0);
        step("x0");
        chk("x0_rw_lit", reg_write, 64'd0);
        chk("x0_wbv_lit", wb_valid, 64'd1);

        drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'hCAFE, 64'd0, 5'd3);
        step("pre_stall");
        chk("pre_stall_cnt_lit", retired_count, 64'd5);
        stall = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'hBAD, 64'd0, 5'd17);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall_rd_lit", rd, 64'd3);
            chk("stall_rw_lit", reg_write, 64'd0);
        end
        chk("stall_cnt_lit", retired_count, 64'd6);

        flush = 1'b1;
        step("stall_flush");
        chk("flush_wbv_lit", wb_valid, 64'd0);
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0, 5'd0);
        step("bubble");

        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 25);
            drive($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
            step("rand");
        end

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        step("wrap_rst");
        reset = 1'b0;
        for (int k = 1; k <= 257; k++) begin
            drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'(k), 64'd0, 5'(k % 31 + 1));
            step("wrap");
            if (k == 256) chk("wrap_max_lit", retired_count, 64'hFF);
        end
        chk("wrap_zero_lit", retired_count, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
